// File: rtl/prf_operand_collector.sv
// Operand collector for one op.
// It gathers the A and B source operands from banked PRF read ports or from the
// writeback bus. It then presents the op with both values until downstream takes it.
module prf_operand_collector #(
  parameter int PRF_BANK_COUNT     = 4,
  parameter int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  parameter int LOG_PR_COUNT       = 7,
  parameter int TAG_WIDTH          = 8
) (
  input  logic                                                    CLK,
  input  logic                                                    nRST,
  input  logic                                                    op_valid,
  output logic                                                    op_ready,
  input  logic [LOG_PR_COUNT-1:0]                                 op_A_PR,
  input  logic [LOG_PR_COUNT-1:0]                                 op_B_PR,
  input  logic                                                    op_A_needed,
  input  logic                                                    op_B_needed,
  input  logic                                                    op_A_ready,
  input  logic                                                    op_B_ready,
  input  logic [TAG_WIDTH-1:0]                                    op_tag,
  input  logic                                                    kill,
  output logic [1:0]                                              reg_read_req_valid,
  output logic [1:0][LOG_PR_COUNT-1:0]                            reg_read_req_PR,
  input  logic [1:0]                                              reg_read_ack,
  input  logic [1:0]                                              reg_read_port,
  input  logic [PRF_BANK_COUNT-1:0][1:0][31:0]                    reg_read_data_by_bank_by_port,
  input  logic [PRF_BANK_COUNT-1:0]                               WB_bus_valid_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][31:0]                         WB_bus_data_by_bank,
  output logic                                                    out_valid,
  input  logic                                                    out_ready,
  output logic [31:0]                                             out_A_data,
  output logic [31:0]                                             out_B_data,
  output logic [TAG_WIDTH-1:0]                                    out_tag
);

  localparam int UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  typedef enum logic [1:0] {EMPTY, COLLECT, OUTPUT} top_state_t;
  typedef enum logic [1:0] {OPND_DONE, OPND_REQ, OPND_DATA, OPND_WAIT_WB} opnd_state_t;

  top_state_t           top_state_reg, top_state_next;
  logic [TAG_WIDTH-1:0] tag_reg, tag_next;
  logic                 accept;
  logic [1:0]           opnd_done_next;
  logic [1:0][31:0]     opnd_data;

  assign op_ready = !kill && ((top_state_reg == EMPTY) ||
                              ((top_state_reg == OUTPUT) && out_ready));
  assign accept   = op_valid && op_ready;

  // Top-level next state: moves to OUTPUT as soon as both operands will be DONE.
  always_comb begin
    top_state_next = top_state_reg;
    tag_next       = accept ? op_tag : tag_reg;
    case (top_state_reg)
      EMPTY:   if (accept) top_state_next = COLLECT;
      COLLECT: if (&opnd_done_next) top_state_next = OUTPUT;
      OUTPUT:  if (out_ready) top_state_next = accept ? COLLECT : EMPTY;
      default: top_state_next = EMPTY;
    endcase
    if (kill) top_state_next = EMPTY;
  end

  // Top-level state and tag registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      top_state_reg <= EMPTY;
      tag_reg       <= '0;
    end else begin
      top_state_reg <= top_state_next;
      tag_reg       <= tag_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      opnd_state_t               state_reg, state_next;
      logic [LOG_PR_COUNT-1:0]   pr_reg, pr_next;
      logic                      port_reg, port_next;
      logic [31:0]               data_reg, data_next;
      logic [LOG_PR_COUNT-1:0]   in_pr;
      logic                      in_needed, in_ready;
      logic [LOG_PRF_BANK_COUNT-1:0] bank;
      logic [UPPER_W-1:0]        upper;
      logic                      wb_match;

      assign in_pr     = (gi == 0) ? op_A_PR     : op_B_PR;
      assign in_needed = (gi == 0) ? op_A_needed : op_B_needed;
      assign in_ready  = (gi == 0) ? op_A_ready  : op_B_ready;
      assign bank      = pr_reg[LOG_PRF_BANK_COUNT-1:0];
      assign upper     = pr_reg[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
      assign wb_match  = WB_bus_valid_by_bank[bank] &&
                         (WB_bus_upper_PR_by_bank[bank] == upper);

      // Operand next state: a writeback hit in REQ beats a same-cycle read grant.
      always_comb begin
        state_next = state_reg;
        pr_next    = pr_reg;
        port_next  = port_reg;
        data_next  = data_reg;
        if (accept) begin
          pr_next   = in_pr;
          data_next = '0;
          if (!in_needed)    state_next = OPND_DONE;
          else if (in_ready) state_next = OPND_REQ;
          else               state_next = OPND_WAIT_WB;
        end else if (kill) begin
          state_next = OPND_DONE;
        end else begin
          case (state_reg)
            OPND_REQ: begin
              if (wb_match) begin
                data_next  = WB_bus_data_by_bank[bank];
                state_next = OPND_DONE;
              end else if (reg_read_ack[gi]) begin
                port_next  = reg_read_port[gi];
                state_next = OPND_DATA;
              end
            end
            OPND_DATA: begin
              data_next  = reg_read_data_by_bank_by_port[bank][port_reg];
              state_next = OPND_DONE;
            end
            OPND_WAIT_WB: begin
              if (wb_match) begin
                data_next  = WB_bus_data_by_bank[bank];
                state_next = OPND_DONE;
              end
            end
            default: state_next = state_reg;
          endcase
        end
      end

      // Operand state, PR, granted port and captured value.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          state_reg <= OPND_DONE;
          pr_reg    <= '0;
          port_reg  <= 1'b0;
          data_reg  <= '0;
        end else begin
          state_reg <= state_next;
          pr_reg    <= pr_next;
          port_reg  <= port_next;
          data_reg  <= data_next;
        end
      end

      assign reg_read_req_valid[gi] = (state_reg == OPND_REQ) && !kill;
      assign reg_read_req_PR[gi]    = pr_reg;
      assign opnd_done_next[gi]     = (state_next == OPND_DONE);
      assign opnd_data[gi]          = data_reg;
    end
  endgenerate

  assign out_valid  = (top_state_reg == OUTPUT);
  assign out_A_data = opnd_data[0];
  assign out_B_data = opnd_data[1];
  assign out_tag    = tag_reg;

endmodule

// File: tb/tb_prf_operand_collector.sv
// Directed bench for prf_operand_collector with an output scoreboard.
module tb_prf_operand_collector;

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic                 op_valid, op_ready;
  logic [6:0]           op_A_PR, op_B_PR;
  logic                 op_A_needed, op_B_needed, op_A_ready, op_B_ready;
  logic [7:0]           op_tag;
  logic                 kill;
  logic [1:0]           reg_read_req_valid;
  logic [1:0][6:0]      reg_read_req_PR;
  logic [1:0]           reg_read_ack, reg_read_port;
  logic [3:0][1:0][31:0] rd_data;
  logic [3:0]           wb_valid;
  logic [3:0][4:0]      wb_upper;
  logic [3:0][31:0]     wb_data;
  logic                 out_valid, out_ready;
  logic [31:0]          out_A_data, out_B_data;
  logic [7:0]           out_tag;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   passed = 0;

  always #5 CLK = ~CLK;

  prf_operand_collector dut (
    .CLK(CLK), .nRST(nRST),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_A_PR(op_A_PR), .op_B_PR(op_B_PR),
    .op_A_needed(op_A_needed), .op_B_needed(op_B_needed),
    .op_A_ready(op_A_ready), .op_B_ready(op_B_ready),
    .op_tag(op_tag), .kill(kill),
    .reg_read_req_valid(reg_read_req_valid), .reg_read_req_PR(reg_read_req_PR),
    .reg_read_ack(reg_read_ack), .reg_read_port(reg_read_port),
    .reg_read_data_by_bank_by_port(rd_data),
    .WB_bus_valid_by_bank(wb_valid), .WB_bus_upper_PR_by_bank(wb_upper),
    .WB_bus_data_by_bank(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_A_data(out_A_data), .out_B_data(out_B_data), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_op(input logic [6:0] a_pr, input logic a_need, input logic a_rdy,
                          input logic [6:0] b_pr, input logic b_need, input logic b_rdy,
                          input logic [7:0] tag);
    op_valid    = 1'b1;
    op_A_PR     = a_pr;  op_A_needed = a_need; op_A_ready = a_rdy;
    op_B_PR     = b_pr;  op_B_needed = b_need; op_B_ready = b_rdy;
    op_tag      = tag;
  endtask

  // Scoreboard: every handshake on the output must match the oldest expected op.
  always @(negedge CLK) begin
    if (nRST && out_valid && out_ready) begin
      check("sb_expected_present", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        $display("out: A=%08h B=%08h tag=%02h", out_A_data, out_B_data, out_tag);
        check("sb_A", out_A_data, e.a);
        check("sb_B", out_B_data, e.b);
        check("sb_tag", out_tag, e.tag);
      end
    end
  end

  initial begin
    nRST = 1'b0; op_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
    op_A_PR = '0; op_B_PR = '0; op_A_needed = 0; op_B_needed = 0;
    op_A_ready = 0; op_B_ready = 0; op_tag = '0;
    reg_read_ack = '0; reg_read_port = '0; rd_data = '0;
    wb_valid = '0; wb_upper = '0; wb_data = '0;

    // Reset values
    #1;
    check("rst_op_ready", op_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", reg_read_req_valid, 0);
    check("rst_A", out_A_data, 0);
    check("rst_B", out_B_data, 0);
    check("rst_tag", out_tag, 0);
    repeat (2) tick();
    nRST = 1'b1;

    // Single A read through bank 1 port 1
    tick(); drive_op(7'h15, 1, 1, 7'h00, 0, 0, 8'h3C); #1;
    check("t1_op_ready", op_ready, 1);
    sb_q.push_back('{a: 32'hDEADBEEF, b: 32'h0, tag: 8'h3C});
    tick(); op_valid = 0; reg_read_ack = 2'b01; reg_read_port = 2'b01; #1;
    check("t1_req_valid", reg_read_req_valid, 2'b01);
    check("t1_req_pr", reg_read_req_PR[0], 7'h15);
    tick(); reg_read_ack = 0; reg_read_port = 0; rd_data[1][1] = 32'hDEADBEEF; #1;
    check("t1_not_yet_valid", out_valid, 0);
    check("t1_req_dropped", reg_read_req_valid, 0);
    tick(); rd_data = '0; #1;
    check("t1_out_valid", out_valid, 1);
    check("t1_A", out_A_data, 32'hDEADBEEF);
    check("t1_B", out_B_data, 0);
    check("t1_tag", out_tag, 8'h3C);

    // Both operands read on different ports, decoys on the other ports
    tick(); drive_op(7'h05, 1, 1, 7'h0A, 1, 1, 8'h21);
    sb_q.push_back('{a: 32'h11111111, b: 32'h22222222, tag: 8'h21});
    tick(); op_valid = 0; reg_read_ack = 2'b11; reg_read_port = 2'b10; #1;
    check("t2_req_valid", reg_read_req_valid, 2'b11);
    check("t2_req_pr_b", reg_read_req_PR[1], 7'h0A);
    tick(); reg_read_ack = 0; reg_read_port = 0;
    rd_data[1][0] = 32'h11111111; rd_data[1][1] = 32'hFFFFFFFF;
    rd_data[2][1] = 32'h22222222; rd_data[2][0] = 32'hEEEEEEEE;
    tick(); rd_data = '0; #1;
    check("t2_out_valid", out_valid, 1);
    check("t2_A", out_A_data, 32'h11111111);
    check("t2_B", out_B_data, 32'h22222222);

    // Ack withheld three cycles
    tick(); drive_op(7'h22, 1, 1, 7'h00, 0, 0, 8'h11);
    sb_q.push_back('{a: 32'hCAFEF00D, b: 32'h0, tag: 8'h11});
    for (int i = 0; i < 3; i++) begin
      tick(); op_valid = 0; #1;
      check("t3_req_repeat", reg_read_req_valid[0], 1);
      check("t3_req_pr", reg_read_req_PR[0], 7'h22);
    end
    tick(); reg_read_ack = 2'b01; reg_read_port = 2'b00; #1;
    check("t3_req_at_ack", reg_read_req_valid, 2'b01);
    tick(); reg_read_ack = 0; rd_data[2][0] = 32'hCAFEF00D; #1;
    check("t3_not_yet_valid", out_valid, 0);
    tick(); rd_data = '0; #1;
    check("t3_out_valid", out_valid, 1);
    check("t3_A", out_A_data, 32'hCAFEF00D);

    // B waits for writeback, with mismatching bus traffic first
    tick(); drive_op(7'h00, 0, 0, 7'h4B, 1, 0, 8'h77);
    sb_q.push_back('{a: 32'h0, b: 32'h12345678, tag: 8'h77});
    tick(); op_valid = 0; #1;
    check("t4_no_req1", reg_read_req_valid, 0);
    tick(); wb_valid = 4'b1000; wb_upper[3] = 5'h13; wb_data[3] = 32'hBAD0BAD0; #1;
    check("t4_no_req2", reg_read_req_valid, 0);
    tick(); wb_valid = 4'b0100; wb_upper[2] = 5'h12; wb_data[2] = 32'hBAD1BAD1; #1;
    check("t4_wrong_bank", out_valid, 0);
    tick(); wb_valid = 4'b1000; wb_upper[3] = 5'h12; wb_data[3] = 32'h12345678; #1;
    check("t4_no_req4", reg_read_req_valid, 0);
    check("t4_not_yet_valid", out_valid, 0);
    tick(); wb_valid = '0; wb_upper = '0; wb_data = '0; #1;
    check("t4_out_valid", out_valid, 1);
    check("t4_B", out_B_data, 32'h12345678);

    // Writeback beats same-cycle ack in REQ
    tick(); drive_op(7'h15, 1, 1, 7'h00, 0, 0, 8'h35);
    sb_q.push_back('{a: 32'hAAAA5555, b: 32'h0, tag: 8'h35});
    tick(); op_valid = 0; reg_read_ack = 2'b01; reg_read_port = 2'b00;
    wb_valid = 4'b0010; wb_upper[1] = 5'h05; wb_data[1] = 32'hAAAA5555; #1;
    check("t5_req_valid", reg_read_req_valid, 2'b01);
    tick(); reg_read_ack = 0; wb_valid = '0; wb_upper = '0; wb_data = '0;
    rd_data[1][0] = 32'hBBBBBBBB; #1;
    check("t5_req_dropped", reg_read_req_valid, 0);
    check("t5_out_valid", out_valid, 1);
    check("t5_A", out_A_data, 32'hAAAA5555);

    // Output stall, then back-to-back accept in OUTPUT
    tick(); rd_data = '0; drive_op(7'h00, 0, 0, 7'h00, 0, 0, 8'h5A); out_ready = 0;
    sb_q.push_back('{a: 32'h0, b: 32'h0, tag: 8'h5A});
    tick(); op_valid = 0; #1;
    check("t6_collect", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); wb_valid = 4'b0001; wb_upper[0] = 5'h00; wb_data[0] = 32'h0000FFFF + i; #1;
      check("t6_stall_valid", out_valid, 1);
      check("t6_stall_tag", out_tag, 8'h5A);
      check("t6_stall_A", out_A_data, 0);
      check("t6_stall_op_ready", op_ready, 0);
    end
    tick(); wb_valid = '0; wb_data = '0; out_ready = 1;
    drive_op(7'h00, 0, 0, 7'h00, 0, 0, 8'h6B); #1;
    check("t6_b2b_op_ready", op_ready, 1);
    sb_q.push_back('{a: 32'h0, b: 32'h0, tag: 8'h6B});
    tick(); op_valid = 0; #1;
    check("t6_b2b_collect", out_valid, 0);
    check("t6_b2b_tag", out_tag, 8'h6B);
    tick(); #1;
    check("t6_b2b_out_valid", out_valid, 1);

    // Kill in COLLECT
    tick(); drive_op(7'h30, 1, 1, 7'h00, 0, 0, 8'h99);
    tick(); op_valid = 0; kill = 1; #1;
    check("t7_kill_req", reg_read_req_valid, 0);
    check("t7_kill_op_ready", op_ready, 0);
    tick(); kill = 0; #1;
    check("t7_after_op_ready", op_ready, 1);
    check("t7_after_out_valid", out_valid, 0);
    check("t7_after_req", reg_read_req_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("t7_idle_req", reg_read_req_valid, 0);
    end

    // Reset while A is in DATA
    tick(); drive_op(7'h15, 1, 1, 7'h00, 0, 0, 8'h44);
    tick(); op_valid = 0; reg_read_ack = 2'b01; reg_read_port = 2'b00;
    tick(); reg_read_ack = 0; rd_data[1][0] = 32'h12341234; #1;
    nRST = 0; #1;
    check("t8_rst_out_valid", out_valid, 0);
    check("t8_rst_req", reg_read_req_valid, 0);
    check("t8_rst_op_ready", op_ready, 1);
    check("t8_rst_A", out_A_data, 0);
    check("t8_rst_tag", out_tag, 0);
    tick(); rd_data = '0; nRST = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check("t8_post_out_valid", out_valid, 0);
      check("t8_post_req", reg_read_req_valid, 0);
    end

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
